icache_dcache_mem_arbiter: RTL and testbench

Shares the single 64-bit RAM read/write port between the icache refill port and the dcache port. Grants one requester at a time and holds the grant for as long as that requester keeps its valid asserted, so a multi-beat line refill (two 64-bit beats for a 16-byte icache line) is never interleaved with the other requester. Sits between the cache tops and the memory/AXI bridge; both caches see the same valid/ready/rdata protocol they would see from RAM directly.

---
 rtl/icache_dcache_mem_arbiter_pkg.sv | 20 ++
 rtl/icache_dcache_mem_arbiter_rr_pick2.sv | 19 +
 rtl/icache_dcache_mem_arbiter.sv | 116 +++++++++++
 tb/tb_icache_dcache_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_dcache_mem_arbiter_pkg.sv
// rtl/icache_dcache_mem_arbiter_pkg.sv - shared widths and grant encodings for the cache/RAM arbiter
package icache_dcache_mem_arbiter_pkg;

    localparam int NPC_ADDR_BUS = 32;
    localparam int XLEN_BUS     = 64;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Grant encodings, also consumed by the bridge and debug logic
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IC   = 2'b01;
    localparam logic [1:0] GNT_DC   = 2'b10;

    typedef enum logic {
        LAST_IC = 1'b0,
        LAST_DC = 1'b1
    } last_grant_e;

endpackage

// File: rtl/icache_dcache_mem_arbiter_rr_pick2.sv
// rtl/icache_dcache_mem_arbiter_rr_pick2.sv - two-way round-robin pick, one-hot output
module arb_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] pick_o
);

    // req_i[0]/pick_o[0] is requester 0; last_i = 1 means requester 1 was served last
    always_comb begin
        pick_o = 2'b00;
        case (req_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = last_i ? 2'b01 : 2'b10;
            default: pick_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/icache_dcache_mem_arbiter.sv
// rtl/icache_dcache_mem_arbiter.sv - shares one RAM port between icache refill and dcache
module icache_dcache_mem_arbiter
    import icache_dcache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = NPC_ADDR_BUS,
    parameter int DATA_W = XLEN_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ic_raddr_i,
    input  logic              ic_raddr_valid_i,
    input  logic [7:0]        ic_rmask_i,
    output logic              ic_rdata_ready_o,
    output logic [DATA_W-1:0] ic_rdata_o,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic              dc_valid_i,
    input  logic              dc_wen_i,
    input  logic [DATA_W-1:0] dc_wdata_i,
    input  logic [7:0]        dc_mask_i,
    output logic              dc_ready_o,
    output logic [DATA_W-1:0] dc_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_valid_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [7:0]        mem_mask_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        grant_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;
    localparam logic [1:0] S_TURN    = 2'd3;

    logic [1:0]  state_q, state_d;
    last_grant_e last_q, last_d;
    logic [1:0]  pick;
    logic        own_ic, own_dc;

    arb_rr_pick2 u_pick (
        .req_i  ({dc_valid_i, ic_raddr_valid_i}),
        .last_i (last_q == LAST_DC),
        .pick_o (pick)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (pick[0])      state_d = S_GRANT_I;
                else if (pick[1]) state_d = S_GRANT_D;
            end
            S_GRANT_I: begin
                if (!ic_raddr_valid_i) begin
                    state_d = S_TURN;
                    last_d  = LAST_IC;
                end
            end
            S_GRANT_D: begin
                if (!dc_valid_i) begin
                    state_d = S_TURN;
                    last_d  = LAST_DC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= LAST_IC;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Outputs are gated by rst so a reset cycle never leaks a request to RAM
    assign own_ic = !rst && (state_q == S_GRANT_I);
    assign own_dc = !rst && (state_q == S_GRANT_D);

    always_comb begin
        mem_addr_o       = '0;
        mem_valid_o      = FALSE;
        mem_wen_o        = FALSE;
        mem_wdata_o      = '0;
        mem_mask_o       = '0;
        ic_rdata_ready_o = FALSE;
        ic_rdata_o       = '0;
        dc_ready_o       = FALSE;
        dc_rdata_o       = '0;
        grant_o          = GNT_NONE;
        if (own_ic) begin
            mem_addr_o       = ic_raddr_i;
            mem_valid_o      = ic_raddr_valid_i;
            mem_mask_o       = ic_rmask_i;
            ic_rdata_ready_o = mem_ready_i;
            ic_rdata_o       = mem_rdata_i;
            grant_o          = GNT_IC;
        end else if (own_dc) begin
            mem_addr_o  = dc_addr_i;
            mem_valid_o = dc_valid_i;
            mem_wen_o   = dc_wen_i;
            mem_wdata_o = dc_wdata_i;
            mem_mask_o  = dc_mask_i;
            dc_ready_o  = mem_ready_i;
            dc_rdata_o  = mem_rdata_i;
            grant_o     = GNT_DC;
        end
    end

endmodule

// File: tb/tb_icache_dcache_mem_arbiter.sv
// tb/tb_icache_dcache_mem_arbiter.sv - table-driven checks for icache_dcache_mem_arbiter
module tb_icache_dcache_mem_arbiter;

    localparam logic [31:0] A  = 32'h8000_0010;
    localparam logic [31:0] B  = 32'h8000_0018;
    localparam logic [31:0] D  = 32'h8000_1000;
    localparam logic [63:0] WD = 64'hDEAD_BEEF_0000_0001;
    localparam logic [7:0]  IM = 8'hF0;
    localparam logic [7:0]  DM = 8'hFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ic_raddr;
    logic        ic_valid;
    logic [7:0]  ic_rmask;
    logic        ic_ready;
    logic [63:0] ic_rdata;
    logic [31:0] dc_addr;
    logic        dc_valid;
    logic        dc_wen;
    logic [63:0] dc_wdata;
    logic [7:0]  dc_mask;
    logic        dc_ready;
    logic [63:0] dc_rdata;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic [1:0]  grant;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    icache_dcache_mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .ic_raddr_i       (ic_raddr),
        .ic_raddr_valid_i (ic_valid),
        .ic_rmask_i       (ic_rmask),
        .ic_rdata_ready_o (ic_ready),
        .ic_rdata_o       (ic_rdata),
        .dc_addr_i        (dc_addr),
        .dc_valid_i       (dc_valid),
        .dc_wen_i         (dc_wen),
        .dc_wdata_i       (dc_wdata),
        .dc_mask_i        (dc_mask),
        .dc_ready_o       (dc_ready),
        .dc_rdata_o       (dc_rdata),
        .mem_addr_o       (mem_addr),
        .mem_valid_o      (mem_valid),
        .mem_wen_o        (mem_wen),
        .mem_wdata_o      (mem_wdata),
        .mem_mask_o       (mem_mask),
        .mem_ready_i      (mem_ready),
        .mem_rdata_i      (mem_rdata),
        .grant_o          (grant)
    );

    typedef struct {
        logic        rst;
        logic        icv;
        logic [31:0] ica;
        logic        dcv;
        logic        dcw;
        logic [31:0] dca;
        logic        mrdy;
        logic [63:0] mrd;
        logic [1:0]  e_gnt;
        logic        e_mv;
        logic [31:0] e_addr;
        logic        e_wen;
        logic        e_icr;
        logic        e_dcr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic icv, input logic [31:0] ica,
                                input logic dcv, input logic dcw, input logic [31:0] dca,
                                input logic mrdy, input logic [63:0] mrd,
                                input logic [1:0] g, input logic mv, input logic [31:0] ad,
                                input logic w, input logic icr, input logic dcr);
        vec_t v;
        v.rst = r; v.icv = icv; v.ica = ica; v.dcv = dcv; v.dcw = dcw; v.dca = dca;
        v.mrdy = mrdy; v.mrd = mrd; v.e_gnt = g; v.e_mv = mv; v.e_addr = ad;
        v.e_wen = w; v.e_icr = icr; v.e_dcr = dcr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; ic_valid = 1'b0; ic_raddr = A; dc_valid = 1'b0; dc_wen = 1'b0;
        dc_addr = D; mem_ready = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        ic_rmask = IM; dc_mask = DM; dc_wdata = WD;
        idle_inputs();
        rst = 1'b1;

        //         rst icv ica dcv dcw dca mrdy mrd        | gnt  mv addr wen icr dcr
        tbl.push_back(mk(1, 1, A, 0, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A, 0, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A, 0, 0, D, 0, 64'h0,    2'd1, 1, A,     0, 0, 0));
        tbl.push_back(mk(0, 1, A, 0, 0, D, 0, 64'h0,    2'd1, 1, A,     0, 0, 0));
        tbl.push_back(mk(0, 1, A, 0, 0, D, 1, 64'h1111, 2'd1, 1, A,     0, 1, 0));
        tbl.push_back(mk(0, 1, B, 1, 0, D, 0, 64'h0,    2'd1, 1, B,     0, 0, 0));
        tbl.push_back(mk(0, 1, B, 1, 0, D, 1, 64'h2222, 2'd1, 1, B,     0, 1, 0));
        tbl.push_back(mk(0, 0, B, 1, 0, D, 0, 64'h0,    2'd1, 0, B,     0, 0, 0));
        tbl.push_back(mk(0, 0, B, 1, 1, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, B, 1, 1, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, B, 1, 1, D, 0, 64'h0,    2'd2, 1, D,     1, 0, 0));
        tbl.push_back(mk(0, 0, B, 1, 1, D, 1, 64'h55,   2'd2, 1, D,     1, 0, 1));
        tbl.push_back(mk(0, 0, B, 0, 0, D, 0, 64'h0,    2'd2, 0, D,     0, 0, 0));
        tbl.push_back(mk(0, 0, B, 0, 0, D, 1, 64'h77,   2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, B, 0, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        // reset, then simultaneous request: dcache first, then alternate
        tbl.push_back(mk(1, 1, A, 1, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A, 1, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A, 1, 0, D, 0, 64'h0,    2'd2, 1, D,     0, 0, 0));
        tbl.push_back(mk(0, 1, A, 1, 0, D, 1, 64'h33,   2'd2, 1, D,     0, 0, 1));
        tbl.push_back(mk(0, 1, A, 0, 0, D, 0, 64'h0,    2'd2, 0, D,     0, 0, 0));
        tbl.push_back(mk(0, 1, A, 0, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A, 0, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A, 1, 0, D, 1, 64'h44,   2'd1, 1, A,     0, 1, 0));
        tbl.push_back(mk(0, 0, A, 1, 0, D, 0, 64'h0,    2'd1, 0, A,     0, 0, 0));
        tbl.push_back(mk(0, 1, A, 1, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A, 1, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A, 1, 0, D, 1, 64'h66,   2'd2, 1, D,     0, 0, 1));
        tbl.push_back(mk(0, 1, A, 0, 0, D, 0, 64'h0,    2'd2, 0, D,     0, 0, 0));
        tbl.push_back(mk(0, 1, A, 1, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, A, 1, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, A, 1, 0, D, 0, 64'h0,    2'd1, 0, A,     0, 0, 0));
        tbl.push_back(mk(0, 0, A, 1, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, A, 1, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, A, 1, 0, D, 0, 64'h0,    2'd2, 1, D,     0, 0, 0));
        // reset mid-grant with a RAM beat that must be dropped
        tbl.push_back(mk(1, 0, A, 1, 0, D, 1, 64'h99,   2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, A, 1, 0, D, 0, 64'h0,    2'd0, 0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, A, 1, 0, D, 0, 64'h0,    2'd2, 1, D,     0, 0, 0));

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            logic [63:0] e_wd, e_ird, e_drd;
            logic [7:0]  e_msk;
            v = tbl[i];
            #1;
            rst = v.rst; ic_valid = v.icv; ic_raddr = v.ica; dc_valid = v.dcv;
            dc_wen = v.dcw; dc_addr = v.dca; mem_ready = v.mrdy; mem_rdata = v.mrd;
            #4;
            e_wd  = (v.e_gnt == 2'd2) ? WD : 64'h0;
            e_msk = (v.e_gnt == 2'd2) ? DM : ((v.e_gnt == 2'd1) ? IM : 8'h0);
            e_ird = (v.e_gnt == 2'd1) ? v.mrd : 64'h0;
            e_drd = (v.e_gnt == 2'd2) ? v.mrd : 64'h0;
            chk($sformatf("row%0d grant", i),     64'(grant),     64'(v.e_gnt));
            chk($sformatf("row%0d mem_valid", i), 64'(mem_valid), 64'(v.e_mv));
            chk($sformatf("row%0d mem_addr", i),  64'(mem_addr),  64'(v.e_addr));
            chk($sformatf("row%0d mem_wen", i),   64'(mem_wen),   64'(v.e_wen));
            chk($sformatf("row%0d mem_wdata", i), mem_wdata,      e_wd);
            chk($sformatf("row%0d mem_mask", i),  64'(mem_mask),  64'(e_msk));
            chk($sformatf("row%0d ic_ready", i),  64'(ic_ready),  64'(v.e_icr));
            chk($sformatf("row%0d dc_ready", i),  64'(dc_ready),  64'(v.e_dcr));
            chk($sformatf("row%0d ic_rdata", i),  ic_rdata,       e_ird);
            chk($sformatf("row%0d dc_rdata", i),  dc_rdata,       e_drd);
            @(posedge clk);
        end

        // dcache write held until RAM completes, with a bounded wait for the grant
        #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; dc_valid = 1'b1; dc_wen = 1'b1; dc_addr = D;
        begin
            int waited;
            waited = 0;
            #4;
            while (grant != 2'd2 && waited < 5) begin
                @(posedge clk);
                #5;
                waited++;
            end
            chk("dc write grant within budget", 64'(grant), 64'd2);
            chk("dc write grant latency", 64'(waited), 64'd1);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wr hold%0d mem_wen", k),   64'(mem_wen),   64'd1);
            chk($sformatf("wr hold%0d mem_wdata", k), mem_wdata,      WD);
            chk($sformatf("wr hold%0d mem_mask", k),  64'(mem_mask),  64'(DM));
            chk($sformatf("wr hold%0d mem_addr", k),  64'(mem_addr),  64'(D));
            chk($sformatf("wr hold%0d dc_ready", k),  64'(dc_ready),  64'd0);
            @(posedge clk);
            #5;
        end
        mem_ready = 1'b1;
        #1;
        chk("wr done dc_ready", 64'(dc_ready), 64'd1);
        chk("wr done ic_ready", 64'(ic_ready), 64'd0);
        chk("wr done mem_wen",  64'(mem_wen),  64'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #5;
        chk("wr release turn grant", 64'(grant), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
